// File: rtl/fifo_pkg.sv
// Shared FSM encoding and default widths for the burst reader family.
package fifo_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int LEN_WIDTH_DEF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/stream_buf2.sv
// 2-entry in-order valid/ready buffer: a push is visible at the head one cycle later.
// Push and pop may coincide; the caller must never push into a full buffer without popping.
module stream_buf2 #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [1:0]            o_count,
   output logic [DATA_WIDTH-1:0] o_head
);
   logic [DATA_WIDTH-1:0] r_ent0;
   logic [DATA_WIDTH-1:0] r_ent1;
   logic [1:0]            r_count;
   logic                  w_pop;
   logic [1:0]            w_cnt_kept;

   assign w_pop      = i_pop && (r_count != 2'd0);
   assign w_cnt_kept = r_count - {1'b0, w_pop};

   // The new word lands in the first slot left occupied-free after this cycle's pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ent0  <= '0;
         r_ent1  <= '0;
         r_count <= 2'd0;
      end else begin
         if (w_pop) begin
            r_ent0 <= r_ent1;
         end
         if (i_push) begin
            if (w_cnt_kept == 2'd0) begin
               r_ent0 <= i_push_data;
            end else begin
               r_ent1 <= i_push_data;
            end
         end
         r_count <= w_cnt_kept + {1'b0, i_push};
      end
   end

   assign o_count = r_count;
   assign o_head  = r_ent0;
endmodule

// File: rtl/fifo_burst_reader.sv
// Reads a len-word burst from a registered-output FIFO into a valid/ready stream.
// First word appears 3 cycles after start; pops are throttled so at most 2 words are ever held.
module fifo_burst_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  fifo_read_en,
   input  logic                  fifo_empty,
   input  logic                  fifo_rvalid,
   input  logic [DATA_WIDTH-1:0] fifo_d_out,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data
);
   localparam int CW = LEN_WIDTH + 1;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_len;
   logic [CW-1:0] r_received;
   logic          r_inflight;
   logic [1:0]    w_buf_count;
   logic [CW-1:0] w_issued;
   logic [2:0]    w_occ;
   logic          w_xfer;
   logic          w_capture;
   logic          w_space;
   logic          w_read_en;

   assign w_xfer    = m_valid && m_ready;
   assign w_capture = fifo_rvalid && r_inflight;
   assign w_issued  = r_received + CW'(r_inflight);
   // Count the word already in flight plus the one about to be requested.
   assign w_occ     = {1'b0, w_buf_count} + 3'(r_inflight) + 3'd1;
   assign w_space   = (w_occ <= (3'd2 + 3'(w_xfer)));

   always_comb begin
      w_state_nxt = r_state;
      w_read_en   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = (len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            w_read_en = !fifo_empty && (w_issued < r_len) && w_space;
            if ((r_received == r_len) && !r_inflight) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_buf_count == 2'd0) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // A pop that upstream did not honour never raises received, so it is simply reissued.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_len      <= '0;
         r_received <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_read_en;
         if ((r_state == ST_IDLE) && start) begin
            r_len      <= CW'(len);
            r_received <= '0;
         end else if (w_capture) begin
            r_received <= r_received + CW'(1);
         end
      end
   end

   stream_buf2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_capture),
      .i_push_data (fifo_d_out),
      .i_pop       (w_xfer),
      .o_count     (w_buf_count),
      .o_head      (m_data)
   );

   assign m_valid      = (w_buf_count != 2'd0);
   assign busy         = (r_state != ST_IDLE);
   assign done         = (r_state == ST_DONE);
   assign fifo_read_en = w_read_en;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomised and directed bench for fifo_burst_reader with an upstream FIFO model and stream scoreboard.
module tb_fifo_burst_reader;
   localparam int DW = 8;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          reset, start, busy, done, fifo_read_en, fifo_empty, fifo_rvalid;
   logic          m_valid, m_ready;
   logic [LW-1:0] len;
   logic [DW-1:0] fifo_d_out, m_data;

   fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy), .done(done),
      .fifo_read_en(fifo_read_en), .fifo_empty(fifo_empty), .fifo_rvalid(fifo_rvalid),
      .fifo_d_out(fifo_d_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] buf_q[$];
   bit            model_busy = 1'b0;
   int            len_cur = 0, delivered = 0, pops = 0, n_req = 0;
   bit            nxt_rvalid = 1'b0, rv_real = 1'b0, stray_req = 1'b0, prev_hold = 1'b0;
   logic [DW-1:0] nxt_dout = '0, prev_data = '0;
   int            ready_mode = 0, empty_mode = 0, drop_mode = 0, drop_left = 0, cyc = 0;

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Upstream FIFO and downstream sink, driven just after each rising edge.
   always @(posedge clk) begin
      bit fe;
      #1;
      cyc++;
      if (stray_req) begin
         fifo_rvalid = 1'b1; rv_real = 1'b0; fifo_d_out = 8'hEE; stray_req = 1'b0;
      end else begin
         fifo_rvalid = nxt_rvalid; rv_real = nxt_rvalid;
         fifo_d_out  = nxt_rvalid ? nxt_dout : DW'($urandom);
      end
      case (empty_mode)
         1:       fe = ((cyc % 2) == 1);
         2:       fe = ($urandom_range(0, 3) == 0);
         default: fe = 1'b0;
      endcase
      fifo_empty = (fifo_q.size() == 0) || fe;
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = 1'b0;
         default: m_ready = ($urandom_range(0, 9) < 7);
      endcase
   end

   // Scoreboard: the stream must replay FIFO words in order, buffered at most two deep.
   always @(negedge clk) begin
      nxt_rvalid = 1'b0;
      if (reset) begin
         buf_q.delete();
         model_busy = 1'b0;
         prev_hold  = 1'b0;
      end else begin
         chk(m_valid == (buf_q.size() != 0), "m_valid", 32'(m_valid), 32'(buf_q.size() != 0));
         if (m_valid && buf_q.size() != 0)
            chk(m_data == buf_q[0], "m_data", 32'(m_data), 32'(buf_q[0]));
         if (prev_hold)
            chk(m_valid && m_data == prev_data, "hold_stable", 32'(m_data), 32'(prev_data));
         chk(busy == model_busy, "busy", 32'(busy), 32'(model_busy));
         if (fifo_read_en) begin
            chk(!fifo_empty, "read_while_empty", 32'(fifo_empty), 32'd0);
            chk(model_busy, "read_while_idle", 32'(model_busy), 32'd1);
         end
         if (done)
            chk(model_busy && delivered == len_cur && buf_q.size() == 0, "done_cond",
                32'(delivered), 32'(len_cur));
         prev_hold = m_valid && !m_ready;
         prev_data = m_data;
         if (m_valid && m_ready && buf_q.size() != 0) begin
            void'(buf_q.pop_front());
            delivered++;
         end
         if (fifo_rvalid && rv_real) buf_q.push_back(fifo_d_out);
         chk(buf_q.size() <= 2, "buf_depth", 32'(buf_q.size()), 32'd2);
         if (fifo_read_en && !fifo_empty) begin
            n_req++;
            if ((drop_mode == 1 && $urandom_range(0, 99) < 15) || (drop_mode == 2 && drop_left > 0)) begin
               if (drop_mode == 2) drop_left--;
            end else begin
               chk(pops < len_cur, "over_read", 32'(pops), 32'(len_cur));
               nxt_rvalid = 1'b1;
               nxt_dout   = fifo_q.pop_front();
               pops++;
            end
         end
         if (done) model_busy = 1'b0;
         else if (!model_busy && start) begin
            model_busy = 1'b1; len_cur = int'(len); delivered = 0; pops = 0;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic preload(input int n, input int base);
      for (int i = 0; i < n; i++)
         fifo_q.push_back((base < 0) ? DW'($urandom) : DW'(base + i));
   endtask

   task automatic start_burst(input int l);
      @(posedge clk); #2;
      start = 1'b1; len = LW'(l);
      @(posedge clk); #2;
      start = 1'b0; len = LW'($urandom);
   endtask

   task automatic wait_done(input int limit, output int n);
      bit ok;
      ok = 1'b0; n = 0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge clk); #1;
         n++;
         if (done) ok = 1'b1;
      end
      chk(ok, "done_timeout", 32'(n), 32'(limit));
   endtask

   initial begin
      int n, req0, l;
      reset = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0;
      fifo_empty = 1'b1; fifo_rvalid = 1'b0; fifo_d_out = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk(!busy && !done, "rst_busy_done", 32'({busy, done}), 32'd0);
      chk(!fifo_read_en && !m_valid, "rst_re_mvalid", 32'({fifo_read_en, m_valid}), 32'd0);
      chk(m_data == '0, "rst_mdata", 32'(m_data), 32'd0);
      @(posedge clk); #2;
      reset = 1'b0;

      // Four words at full rate: read T+1, first data T+3, done T+8.
      preload(4, 'h11); idle(3);
      start_burst(4);
      @(negedge clk); #1;
      chk(fifo_read_en, "t1_read_T1", 32'(fifo_read_en), 32'd1);
      @(negedge clk); #1;
      chk(!m_valid, "t1_mvalid_T2", 32'(m_valid), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         chk(m_valid && m_data == DW'('h11 + k), "t1_data", 32'(m_data), 32'('h11 + k));
      end
      @(negedge clk); #1;
      chk(!done && busy, "t1_drain", 32'({busy, done}), 32'b10);
      @(negedge clk); #1;
      chk(done, "t1_done_T8", 32'(done), 32'd1);
      @(negedge clk); #1;
      chk(!done && !busy, "t1_idle", 32'({busy, done}), 32'd0);

      // Zero-length burst.
      fifo_q.delete(); preload(2, 'h55); idle(3);
      start_burst(0);
      @(negedge clk); #1;
      chk(done && busy, "t2_done_T1", 32'({busy, done}), 32'b11);
      chk(!fifo_read_en && !m_valid, "t2_no_read", 32'({fifo_read_en, m_valid}), 32'd0);
      @(negedge clk); #1;
      chk(!done && !busy, "t2_idle", 32'({busy, done}), 32'd0);
      chk(fifo_q.size() == 2, "t2_no_pop", 32'(fifo_q.size()), 32'd2);

      // Downstream stalled for ten cycles.
      fifo_q.delete(); preload(5, 'h21); ready_mode = 1; idle(3);
      start_burst(5);
      repeat (10) @(negedge clk);
      #1;
      chk(pops == 2, "t3_stall_pops", 32'(pops), 32'd2);
      chk(m_valid && m_data == 8'h21, "t3_head", 32'(m_data), 32'h21);
      ready_mode = 0;
      wait_done(100, n);
      chk(delivered == 5, "t3_count", 32'(delivered), 32'd5);

      // FIFO empty every other cycle, random sink.
      fifo_q.delete(); preload(8, -1); empty_mode = 1; ready_mode = 2; idle(3);
      start_burst(6);
      wait_done(300, n);
      chk(delivered == 6, "t4_count", 32'(delivered), 32'd6);
      chk(fifo_q.size() == 2, "t4_left", 32'(fifo_q.size()), 32'd2);
      empty_mode = 0; ready_mode = 0;

      // One pop refused upstream must be reissued.
      fifo_q.delete(); preload(3, 'h31); drop_mode = 2; drop_left = 1; idle(3);
      req0 = n_req;
      start_burst(3);
      wait_done(100, n);
      chk(n_req - req0 == 4, "t5_reissue", 32'(n_req - req0), 32'd4);
      chk(delivered == 3 && drop_left == 0, "t5_count", 32'(delivered), 32'd3);
      drop_mode = 0;

      // Reset mid-burst, then a clean burst.
      fifo_q.delete(); preload(8, -1); idle(3);
      start_burst(8);
      for (int i = 0; i < 50 && delivered < 2; i++) begin
         @(negedge clk); #1;
      end
      chk(delivered >= 2, "t6_reached", 32'(delivered), 32'd2);
      @(posedge clk); #2;
      reset = 1'b1; stray_req = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk); #1;
      chk({busy, done, fifo_read_en, m_valid} == 4'b0, "t6_outputs",
          32'({busy, done, fifo_read_en, m_valid}), 32'd0);
      chk(m_data == '0, "t6_mdata", 32'(m_data), 32'd0);
      @(negedge clk); #1;
      chk(!m_valid && !done, "t6_stray_ignored", 32'({m_valid, done}), 32'd0);
      fifo_q.delete(); preload(3, 'h41); idle(3);
      start_burst(3);
      wait_done(100, n);
      chk(delivered == 3, "t6_new_burst", 32'(delivered), 32'd3);

      // Random bursts with throttling, drops and backpressure.
      for (int b = 0; b < 8; b++) begin
         fifo_q.delete();
         l = $urandom_range(1, 12);
         preload(l + 2, -1);
         empty_mode = 2; drop_mode = 1; ready_mode = 2; idle(3);
         start_burst(l);
         wait_done(600, n);
         chk(delivered == l, "rand_count", 32'(delivered), 32'(l));
         empty_mode = 0; drop_mode = 0; ready_mode = 0; idle(2);
      end

      // Maximum length at one word per cycle.
      fifo_q.delete(); preload(255, -1); idle(3);
      start_burst(255);
      wait_done(400, n);
      chk(n == 259, "t7_done_cycle", 32'(n), 32'd259);
      chk(delivered == 255, "t7_count", 32'(delivered), 32'd255);

      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end
endmodule
